bus_lsu: RTL and testbench
==========================

BUS_LSU -- requirements
Module: bus_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256: bus wait limit in cycles per transfer.
REQ-002 SHALL have parameter SIGN_EXT, default 1: 1 enables req_signed loads.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  core request present.
REQ-006 SHALL have port req_ready  out  1  request accepted this cycle.
REQ-007 SHALL have port req_we  in  1  1=store, 0=load.
REQ-008 SHALL have port req_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-009 SHALL have port req_signed  in  1  sign-extend sub-word loads.
REQ-010 SHALL have port req_addr  in  32  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, LSB-aligned.
REQ-012 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  out  32  load result, extended.
REQ-014 SHALL have port resp_err  out  1  misaligned, illegal size or timeout.
REQ-015 SHALL have port BUS_addr  out  32  word-aligned bus address (bits 1:0 = 0).
REQ-016 SHALL have port BUS_wdata  out  32  bus write word.
REQ-017 SHALL have port BUS_rdata  in  32  bus read word.
REQ-018 SHALL have port BUS_valid  out  1  bus request active.
REQ-019 SHALL have port BUS_mode  out  1  1=write, 0=read.
REQ-020 SHALL have port BUS_wready  in  1  slave accepted write.
REQ-021 SHALL have port BUS_rvalid  in  1  slave read data valid.
REQ-022 SHALL have port BUS_rready  out  1  master accepts read data.

Function
REQ-023 SHALL implement FSM states IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
REQ-024 SHALL assert req_ready only in IDLE; a request is accepted on req_valid&&req_ready, and addr/size/we/wdata/signed are registered.
REQ-025 SHALL, on acceptance with size 3, half at odd addr or word at addr[1:0]!=0, go to RESP with resp_err=1 and issue no bus transfer.
REQ-026 SHALL route: load -> RD; word store -> WR; byte/half store -> RMW_RD.
REQ-027 SHALL in RD/RMW_RD drive BUS_valid=1, BUS_mode=0, BUS_rready=1; transfer completes on BUS_rvalid&&BUS_rready.
REQ-028 SHALL in WR/RMW_WR drive BUS_valid=1, BUS_mode=1, BUS_rready=0; transfer completes on BUS_wready.
REQ-029 SHALL hold BUS_addr, BUS_wdata, BUS_mode stable while BUS_valid=1 until completion.
REQ-030 SHALL in RMW_RD capture BUS_rdata, merge the byte/half into lane addr[1:0] (little-endian), then go to RMW_WR with the merged word.
REQ-031 SHALL on RD completion extract the lane, zero-extend, or sign-extend when req_signed&&SIGN_EXT; word passes unchanged.
REQ-032 SHALL in RESP pulse resp_valid for exactly one cycle, then return to IDLE; resp_rdata=0 for stores and errors.
REQ-033 SHALL count wait cycles per bus state; reaching TIMEOUT_CYC without completion drops BUS_valid and goes to RESP with resp_err=1.
REQ-034 SHALL give latency: accept cycle + N bus wait cycles + 1 RESP cycle; zero-wait load -> resp_valid 2 cycles after acceptance; zero-wait RMW -> 3.
REQ-035 SHALL ignore BUS_rvalid/BUS_wready outside the matching state; no new request is accepted before RESP completes.

Reset
REQ-036 SHALL on rst_n=0 at a clk edge enter IDLE, clear the counter, drive BUS_valid=0, BUS_rready=0, BUS_mode=0, BUS_addr=0, BUS_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=0 during reset and 1 the cycle after.
REQ-037 SHALL abandon any in-flight transfer on reset without a response.

Structure
REQ-038 SHALL take state encoding, size codes (SZ_B/SZ_H/SZ_W) and BUS_MODE_RD/WR constants from shared package bus_pkg.
REQ-039 SHALL place lane extract/merge in combinational sub-module lsu_lane (load extend + store merge).

Verification
REQ-040 SHALL cover word load addr 0x10, slave rdata 0xDEADBEEF, 0 wait -> resp_rdata=0xDEADBEEF, resp_err=0, 2 cycles.
REQ-041 SHALL cover signed byte load addr 0x13, rdata 0x80112233 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-042 SHALL cover byte store 0xAB to 0x21, memory word 0x11223344 -> bus write 0x1122AB44 at 0x20.
REQ-043 SHALL cover half load at 0x05 -> resp_err=1, BUS_valid never asserted.
REQ-044 SHALL cover slave never asserting wready, TIMEOUT_CYC=8 -> BUS_valid drops after 8 cycles, resp_err=1.
REQ-045 SHALL cover rst_n low during RMW_RD wait -> IDLE next cycle, no resp_valid, BUS_valid=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the load/store unit: FSM states, access sizes, bus modes.
// Latency: none (package only).
// Backpressure: none (package only).
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  localparam logic BUS_MODE_RD = 1'b0;
  localparam logic BUS_MODE_WR = 1'b1;

  // True when the access cannot be issued: illegal size or not naturally aligned.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: extends a loaded lane and merges a sub-word store into a word.
// Latency: purely combinational.
// Backpressure: none; ports: bus_word/lane/size/sext/st_data in, ld_data/merged out.
module lsu_lane
  import bus_pkg::*;
(
  input  logic [31:0] bus_word,  // word read from the bus
  input  logic [1:0]  lane,      // byte offset within the word (little-endian)
  input  logic [1:0]  size,      // SZ_B / SZ_H / SZ_W
  input  logic        sext,      // sign-extend sub-word loads
  input  logic [31:0] st_data,   // LSB-aligned store data
  output logic [31:0] ld_data,   // extended load result
  output logic [31:0] merged     // bus_word with the store lane replaced
);

  logic [4:0]  sh;
  logic [31:0] shifted;

  always_comb begin
    sh      = {lane, 3'b000};
    shifted = bus_word >> sh;
    // Word accesses are always lane 0, so the shifted word is the word itself.
    ld_data = shifted;
    merged  = st_data;
    case (size)
      SZ_B: begin
        ld_data = {{24{sext & shifted[7]}}, shifted[7:0]};
        merged  = (bus_word & ~(32'h0000_00FF << sh)) | ({24'b0, st_data[7:0]} << sh);
      end
      SZ_H: begin
        ld_data = {{16{sext & shifted[15]}}, shifted[15:0]};
        merged  = (bus_word & ~(32'h0000_FFFF << sh)) | ({16'b0, st_data[15:0]} << sh);
      end
      default: begin
        ld_data = shifted;
        merged  = st_data;
      end
    endcase
  end

endmodule

// File: rtl/bus_lsu.sv
// Load/store unit: one core request at a time onto a word bus, sub-word stores via read-modify-write.
// Latency: accept cycle + bus cycles (incl. waits) + 1 RESP cycle; zero-wait load 2, zero-wait RMW 3.
// Backpressure: req_ready only in IDLE; bus stalls bounded by TIMEOUT_CYC, then error response.
// Ports: clk/rst_n; core req_* in, req_ready out; resp_valid/resp_rdata/resp_err out;
//        bus BUS_addr/BUS_wdata/BUS_valid/BUS_mode/BUS_rready out, BUS_rdata/BUS_wready/BUS_rvalid in.
module bus_lsu
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int SIGN_EXT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] BUS_addr,
  output logic [31:0] BUS_wdata,
  input  logic [31:0] BUS_rdata,
  output logic        BUS_valid,
  output logic        BUS_mode,
  input  logic        BUS_wready,
  input  logic        BUS_rvalid,
  output logic        BUS_rready
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;   // store data, then the merged word in RMW_WR
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] ld_data;
  logic [31:0] merged;
  logic        timeout;

  lsu_lane u_lane (
    .bus_word (BUS_rdata),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .sext     (signed_q && (SIGN_EXT != 0)),
    .st_data  (wdata_q),
    .ld_data  (ld_data),
    .merged   (merged)
  );

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    timeout  = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = 1'b0;
          cnt_d    = '0;
          if (is_bad_access(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!req_we) begin
            state_d = RD;
          end else if (req_size == SZ_W) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD: begin
        if (BUS_rvalid && BUS_rready) begin
          rdata_d = ld_data;
          state_d = RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RMW_RD: begin
        if (BUS_rvalid && BUS_rready) begin
          wdata_d = merged;
          cnt_d   = '0;       // write phase gets its own wait budget
          state_d = RMW_WR;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WR, RMW_WR: begin
        if (BUS_wready) begin
          state_d = RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: everything is forced low while reset is held.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    BUS_valid  = 1'b0;
    BUS_mode   = BUS_MODE_RD;
    BUS_rready = 1'b0;
    BUS_addr   = 32'h0;
    BUS_wdata  = 32'h0;
    if (rst_n) begin
      BUS_addr  = {addr_q[31:2], 2'b00};
      BUS_wdata = wdata_q;
      case (state_q)
        IDLE: req_ready = 1'b1;
        RD, RMW_RD: begin
          BUS_valid  = 1'b1;
          BUS_rready = 1'b1;
        end
        WR, RMW_WR: begin
          BUS_valid = 1'b1;
          BUS_mode  = BUS_MODE_WR;
        end
        RESP: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
          resp_rdata = rdata_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_lsu.sv
// Scoreboard bench for bus_lsu: directed cases plus random loads/stores against a word-memory model.
// Latency: checks response cycle and number of bus-valid cycles per request.
// Backpressure: slave inserts programmable wait states, or never answers to force timeouts.
module tb_bus_lsu;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] BUS_addr, BUS_wdata, BUS_rdata;
  logic        BUS_valid, BUS_mode, BUS_wready, BUS_rvalid, BUS_rready;

  bus_lsu #(.TIMEOUT_CYC(TMO), .SIGN_EXT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .BUS_addr   (BUS_addr),
    .BUS_wdata  (BUS_wdata),
    .BUS_rdata  (BUS_rdata),
    .BUS_valid  (BUS_valid),
    .BUS_mode   (BUS_mode),
    .BUS_wready (BUS_wready),
    .BUS_rvalid (BUS_rvalid),
    .BUS_rready (BUS_rready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          bus_cyc;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t        sb_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem[16];
  logic [31:0] ref_mem[16];
  int          total, bad, cyc, slave_wait, bus_cnt;
  bit          dead;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // Reference model: word memory, byte lanes computed with masks and shifts.
  task automatic model(input bit we, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input int acc);
    exp_t        e;
    int          idx;
    int          sh;
    int          xfers;
    logic [31:0] w, v, mask, nw;
    bit          err;
    idx = int'(a[5:2]);
    w   = ref_mem[idx];
    sh  = 8 * int'(a[1:0]);
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    e.rdata = 32'h0;
    e.acc   = acc;
    xfers   = 0;
    nw      = w;
    if (!err && !we) begin
      xfers = 1;
      if (sz == 2'd0) begin
        v = (w >> sh) & 32'hFF;
        if (sg && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 2'd1) begin
        v = (w >> sh) & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v - 32'd65536;
      end else begin
        v = w;
      end
      e.rdata = v;
    end else if (!err) begin
      mask  = (sz == 2'd2) ? 32'hFFFF_FFFF : (sz == 2'd1) ? (32'hFFFF << sh) : (32'hFF << sh);
      nw    = (w & ~mask) | ((wd << sh) & mask);
      xfers = (sz == 2'd2) ? 1 : 2;
    end
    if (!err && dead) begin
      err       = 1'b1;
      e.rdata   = 32'h0;
      e.bus_cyc = TMO;
      e.lat     = TMO + 1;
    end else begin
      e.bus_cyc = xfers * (1 + slave_wait);
      e.lat     = e.bus_cyc + 1;
      if (we && !err) begin
        ref_mem[idx] = nw;
        wr_q.push_back(wr_t'{a & ~32'h3, nw});
      end
    end
    e.err = err;
    sb_q.push_back(e);
  endtask

  // Bus slave plus bus-side checks (hold stability, alignment, write contents).
  initial begin
    int          wcnt;
    bit          pv, pdone, done;
    logic [31:0] pa, pw;
    logic        pm;
    wr_t         wexp;
    wcnt = 0; pv = 0; pdone = 0; pa = 0; pw = 0; pm = 0;
    BUS_rvalid = 1'b0;
    BUS_wready = 1'b0;
    BUS_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      done = 0;
      if (!rst_n) begin
        wcnt = 0; pv = 0; bus_cnt = 0;
        BUS_rvalid = 1'b0;
        BUS_wready = 1'b0;
        continue;
      end
      BUS_rdata  = mem[BUS_addr[5:2]];
      BUS_rvalid = 1'($urandom_range(0, 1));
      BUS_wready = 1'($urandom_range(0, 1));
      if (BUS_valid) begin
        bus_cnt++;
        chk("bus_addr_align", {30'b0, BUS_addr[1:0]}, 32'h0);
        if (pv && !pdone) begin
          chk("bus_addr_hold", BUS_addr, pa);
          chk("bus_wdata_hold", BUS_wdata, pw);
          chk("bus_mode_hold", 32'(BUS_mode), 32'(pm));
        end
        if (!dead && wcnt == slave_wait) begin
          done = 1;
          wcnt = 0;
          if (BUS_mode) begin
            BUS_wready = 1'b1;
            if (wr_q.size() == 0) begin
              chk("bus_write_unexpected", BUS_addr, 32'hFFFF_FFFF);
            end else begin
              wexp = wr_q.pop_front();
              chk("bus_write_addr", BUS_addr, wexp.addr);
              chk("bus_write_data", BUS_wdata, wexp.data);
            end
            mem[BUS_addr[5:2]] = BUS_wdata;
          end else begin
            BUS_rvalid = 1'b1;
          end
        end else begin
          wcnt++;
          if (BUS_mode) BUS_wready = 1'b0;
          else          BUS_rvalid = 1'b0;
        end
      end else begin
        wcnt = 0;
      end
      pv = BUS_valid; pdone = done; pa = BUS_addr; pw = BUS_wdata; pm = BUS_mode;
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'h0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("bus_valid_cycles", 32'(bus_cnt), 32'(e.bus_cyc));
          bus_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit expect_resp);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    if (expect_resp) model(we, sz, sg, a, wd, cyc);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", 32'(sb_q.size()), 32'h0);
    sb_q.delete();
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  initial begin
    total = 0; bad = 0; bus_cnt = 0; slave_wait = 0; dead = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_bus_valid", 32'(BUS_valid), 32'h0);
    chk("rst_bus_rready", 32'(BUS_rready), 32'h0);
    chk("rst_bus_mode", 32'(BUS_mode), 32'h0);
    chk("rst_bus_addr", BUS_addr, 32'h0);
    chk("rst_bus_wdata", BUS_wdata, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'h1);

    // Directed cases, zero wait.
    set_word(4, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    drain();
    set_word(4, 32'h8011_2233);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1);
    set_word(8, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, 1'b1);
    drain();
    chk("rmw_byte_word", mem[8], 32'h1122_AB44);

    // Slave never answers: timeout on a word store and on a load.
    dead = 1;
    issue(1'b1, 2'd2, 1'b0, 32'h0C, 32'h1234_5678, 1'b1);
    issue(1'b0, 2'd1, 1'b1, 32'h1A, 32'h0, 1'b1);
    drain();

    // Reset while the RMW read is stalled: transfer abandoned, no response.
    issue(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_0055, 1'b0);
    repeat (2) @(negedge clk);
    chk("rmw_rd_stalled_valid", 32'(BUS_valid), 32'h1);
    chk("rmw_rd_stalled_mode", 32'(BUS_mode), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_bus_valid", 32'(BUS_valid), 32'h0);
    chk("abort_resp_valid", 32'(resp_valid), 32'h0);
    chk("abort_req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    dead  = 0;
    @(negedge clk);
    chk("abort_idle_ready", 32'(req_ready), 32'h1);
    chk("abort_no_resp", 32'(resp_valid), 32'h0);

    // Random traffic in batches with varying slave wait states.
    for (int b = 0; b < 10; b++) begin
      slave_wait = $urandom_range(0, 2);
      for (int k = 0; k < 30; k++) begin
        issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)), $urandom, 1'b1);
      end
      drain();
    end

    repeat (4) @(negedge clk);
    chk("writes_pending", 32'(wr_q.size()), 32'h0);
    for (int i = 0; i < 16; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
